// File: rtl/opll_dac_pkg.sv
// Shared types, widths and saturation limits for the OPLL audio DAC output stage.
package opll_dac_pkg;

  localparam int IN_W    = 16;
  localparam int PWM_W   = 8;
  localparam int DS2_W   = 20;
  localparam int SHIFT_W = IN_W + 3;
  localparam int ACC2_W  = DS2_W + 2;

  typedef enum logic [1:0] {
    DAC_DS1 = 2'b00,
    DAC_DS2 = 2'b01,
    DAC_PWM = 2'b10,
    DAC_RAW = 2'b11
  } dac_mode_e;

  localparam logic signed [IN_W-1:0]    SMP_MAX   = {1'b0, {(IN_W-1){1'b1}}};
  localparam logic signed [IN_W-1:0]    SMP_MIN   = {1'b1, {(IN_W-1){1'b0}}};
  localparam logic signed [SHIFT_W-1:0] SHIFT_MAX = {{(SHIFT_W-IN_W){1'b0}}, SMP_MAX};
  localparam logic signed [SHIFT_W-1:0] SHIFT_MIN = {{(SHIFT_W-IN_W){1'b1}}, SMP_MIN};

  localparam logic signed [DS2_W-1:0]  DS2_MAX    = {1'b0, {(DS2_W-1){1'b1}}};
  localparam logic signed [DS2_W-1:0]  DS2_MIN    = {1'b1, {(DS2_W-1){1'b0}}};
  // 1-bit quantiser feedback levels, expressed at loop precision
  localparam logic signed [ACC2_W-1:0] DS2_FB_POS = {{(ACC2_W-IN_W){1'b0}}, SMP_MAX};
  localparam logic signed [ACC2_W-1:0] DS2_FB_NEG = {{(ACC2_W-IN_W){1'b1}}, SMP_MIN};

  function automatic logic signed [DS2_W-1:0] sat_ds2(input logic signed [ACC2_W-1:0] v);
    logic signed [ACC2_W-1:0] hi;
    logic signed [ACC2_W-1:0] lo;
    logic signed [DS2_W-1:0]  r;
    hi = {{(ACC2_W-DS2_W){1'b0}}, DS2_MAX};
    lo = {{(ACC2_W-DS2_W){1'b1}}, DS2_MIN};
    if (v > hi) begin
      r = DS2_MAX;
    end else if (v < lo) begin
      r = DS2_MIN;
    end else begin
      r = v[DS2_W-1:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/opll_dac_ds2.sv
// Second-order 1-bit delta-sigma loop with saturating integrators.
// y_next_o is the comparator result for this edge; clr_i zeroes the loop state.
module opll_dac_ds2
  import opll_dac_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr_i,
  input  logic signed [IN_W-1:0] x_i,
  output logic                   y_next_o
);

  logic signed [DS2_W-1:0]  i1_q, i1_d;
  logic signed [DS2_W-1:0]  i2_q, i2_d;
  logic                     y_q, y_d;
  logic signed [ACC2_W-1:0] x_ext, fb_ext, sum1, sum2;

  always_comb begin
    x_ext  = {{(ACC2_W-IN_W){x_i[IN_W-1]}}, x_i};
    fb_ext = y_q ? DS2_FB_POS : DS2_FB_NEG;
    sum1   = {{(ACC2_W-DS2_W){i1_q[DS2_W-1]}}, i1_q} + x_ext - fb_ext;
    i1_d   = sat_ds2(sum1);
    sum2   = {{(ACC2_W-DS2_W){i2_q[DS2_W-1]}}, i2_q}
           + {{(ACC2_W-DS2_W){i1_d[DS2_W-1]}}, i1_d} - fb_ext;
    i2_d   = sat_ds2(sum2);
    y_d    = ~i2_d[DS2_W-1];
  end

  assign y_next_o = y_d;

  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      i1_q <= '0;
      i2_q <= '0;
      y_q  <= 1'b0;
    end else begin
      i1_q <= i1_d;
      i2_q <= i2_d;
      y_q  <= y_d;
    end
  end

endmodule

// File: rtl/opll_audio_dac.sv
// OPLL audio output stage: gain/saturate the mixed sample, hold it as offset binary,
// and drive a 1-bit DAC (DS1, DS2, PWM or raw sign) plus an 8-bit parallel copy.
module opll_audio_dac
  import opll_dac_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic signed [IN_W-1:0] i_sample,
  input  logic                   i_strb,
  input  logic [1:0]             i_gain,
  input  logic [1:0]             i_mode,
  output logic                   o_bit,
  output logic [PWM_W-1:0]       o_u8,
  output logic                   o_valid,
  output logic                   o_clip
);

  logic signed [IN_W-1:0]    hold_q, hold_d;
  logic                      valid_q, valid_d;
  logic                      clip_q, clip_d;
  logic                      bit_q, bit_d;
  logic [IN_W:0]             acc_q, acc_d;
  logic [PWM_W-1:0]          cnt_q, cnt_d;
  logic [PWM_W-1:0]          duty_q, duty_d;
  dac_mode_e                 mode_q, mode_in;
  logic                      mode_chg;
  logic                      ds2_y;
  logic signed [SHIFT_W-1:0] smp_shift;
  logic signed [IN_W-1:0]    smp_sat;
  logic                      smp_clip;
  logic [IN_W-1:0]           u;

  assign mode_in  = dac_mode_e'(i_mode);
  assign mode_chg = (mode_in != mode_q);
  assign u        = {~hold_q[IN_W-1], hold_q[IN_W-2:0]};
  assign o_u8     = u[IN_W-1 -: PWM_W];
  assign o_bit    = bit_q;
  assign o_valid  = valid_q;
  assign o_clip   = clip_q;

  // Sign-extend before shifting so the full product is visible to the clamp.
  always_comb begin
    smp_shift = {{(SHIFT_W-IN_W){i_sample[IN_W-1]}}, i_sample} <<< i_gain;
    smp_sat   = smp_shift[IN_W-1:0];
    smp_clip  = 1'b0;
    if (smp_shift > SHIFT_MAX) begin
      smp_sat  = SMP_MAX;
      smp_clip = 1'b1;
    end else if (smp_shift < SHIFT_MIN) begin
      smp_sat  = SMP_MIN;
      smp_clip = 1'b1;
    end
  end

  always_comb begin
    hold_d  = i_strb ? smp_sat : hold_q;
    valid_d = i_strb;
    clip_d  = i_strb & smp_clip;
  end

  always_comb begin
    acc_d  = {1'b0, acc_q[IN_W-1:0]} + {1'b0, u};
    cnt_d  = cnt_q + PWM_W'(1);
    duty_d = (cnt_q == {PWM_W{1'b1}}) ? u[IN_W-1 -: PWM_W] : duty_q;
    bit_d  = 1'b0;
    case (mode_in)
      DAC_DS1: bit_d = acc_d[IN_W];
      DAC_DS2: bit_d = ds2_y;
      DAC_PWM: bit_d = (cnt_q < duty_q);
      DAC_RAW: bit_d = hold_q[IN_W-1];
      default: bit_d = 1'b0;
    endcase
    // A mode change spends one silent cycle restarting every modulator from zero.
    if (mode_chg) begin
      acc_d  = '0;
      cnt_d  = '0;
      duty_d = '0;
      bit_d  = 1'b0;
    end
  end

  opll_dac_ds2 u_ds2 (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (mode_chg),
    .x_i      (hold_q),
    .y_next_o (ds2_y)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_q  <= '0;
      valid_q <= 1'b0;
      clip_q  <= 1'b0;
      bit_q   <= 1'b0;
      acc_q   <= '0;
      cnt_q   <= '0;
      duty_q  <= '0;
      mode_q  <= DAC_DS1;
    end else begin
      hold_q  <= hold_d;
      valid_q <= valid_d;
      clip_q  <= clip_d;
      bit_q   <= bit_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      duty_q  <= duty_d;
      mode_q  <= mode_in;
    end
  end

endmodule

// File: tb/tb_opll_audio_dac.sv
// Self-checking bench for opll_audio_dac against an arithmetic reference model.
module tb_opll_audio_dac;

  logic               clk = 1'b0;
  logic               rst;
  logic signed [15:0] i_sample;
  logic               i_strb;
  logic [1:0]         i_gain;
  logic [1:0]         i_mode;
  logic               o_bit;
  logic [7:0]         o_u8;
  logic               o_valid;
  logic               o_clip;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  opll_audio_dac dut (
    .clk      (clk),
    .rst      (rst),
    .i_sample (i_sample),
    .i_strb   (i_strb),
    .i_gain   (i_gain),
    .i_mode   (i_mode),
    .o_bit    (o_bit),
    .o_u8     (o_u8),
    .o_valid  (o_valid),
    .o_clip   (o_clip)
  );

  // Reference: value held after gain and clamp, and its offset-binary top byte.
  function automatic int ref_full(input int smp, input int g);
    return smp * (1 << g);
  endfunction

  function automatic int ref_hold(input int smp, input int g);
    int s;
    s = ref_full(smp, g);
    if (s > 32767) s = 32767;
    if (s < -32768) s = -32768;
    return s;
  endfunction

  function automatic logic [7:0] ref_u8(input int h);
    return 8'((h + 32768) / 256);
  endfunction

  function automatic logic ref_clip(input int smp, input int g);
    return (ref_full(smp, g) > 32767) || (ref_full(smp, g) < -32768);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n, output int ones);
    ones = 0;
    repeat (n) begin
      step();
      ones += int'(o_bit);
    end
  endtask

  task automatic capture(input logic signed [15:0] smp, input logic [1:0] g);
    i_sample = smp;
    i_gain   = g;
    i_strb   = 1'b1;
    step();
    i_strb   = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; i_strb = 1'b0; i_sample = 16'sh1234; i_gain = 2'd0; i_mode = 2'b00;
    repeat (3) step();
    n_cmp++; if (o_bit !== 1'b0)   begin n_bad++; $display("FAIL rst_bit: got %b want 0", o_bit); end
    n_cmp++; if (o_u8 !== 8'h80)   begin n_bad++; $display("FAIL rst_u8: got %h want 80", o_u8); end
    n_cmp++; if (o_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid: got %b want 0", o_valid); end
    n_cmp++; if (o_clip !== 1'b0)  begin n_bad++; $display("FAIL rst_clip: got %b want 0", o_clip); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_capture();
    capture(16'sh1234, 2'd0);
    n_cmp++; if (o_valid !== 1'b1) begin n_bad++; $display("FAIL cap_valid: got %b want 1", o_valid); end
    n_cmp++; if (o_u8 !== 8'h92)   begin n_bad++; $display("FAIL cap_u8: got %h want 92", o_u8); end
    n_cmp++; if (o_clip !== 1'b0)  begin n_bad++; $display("FAIL cap_clip: got %b want 0", o_clip); end
    step();
    n_cmp++; if (o_valid !== 1'b0) begin n_bad++; $display("FAIL cap_valid_pulse: got %b want 0", o_valid); end
  endtask

  task automatic test_gain_sat();
    capture(16'sh3000, 2'd2);
    n_cmp++; if (o_clip !== 1'b1) begin n_bad++; $display("FAIL sat_pos_clip: got %b want 1", o_clip); end
    n_cmp++; if (o_u8 !== 8'hFF)  begin n_bad++; $display("FAIL sat_pos_u8: got %h want ff", o_u8); end
    capture(-16'sh6000, 2'd1);
    n_cmp++; if (o_clip !== 1'b1) begin n_bad++; $display("FAIL sat_neg_clip: got %b want 1", o_clip); end
    n_cmp++; if (o_u8 !== 8'h00)  begin n_bad++; $display("FAIL sat_neg_u8: got %h want 00", o_u8); end
    step();
    n_cmp++; if (o_clip !== 1'b0) begin n_bad++; $display("FAIL sat_clip_pulse: got %b want 0", o_clip); end
  endtask

  task automatic test_random_capture();
    logic signed [15:0] smp;
    logic [1:0]         g;
    for (int k = 0; k < 24; k++) begin
      smp = 16'($urandom);
      g   = 2'($urandom);
      capture(smp, g);
      n_cmp++;
      if (o_u8 !== ref_u8(ref_hold(int'(smp), int'(g)))) begin
        n_bad++;
        $display("FAIL rnd_u8[%0d]: got %h want %h (smp %0d gain %0d)", k, o_u8,
                 ref_u8(ref_hold(int'(smp), int'(g))), smp, g);
      end
      n_cmp++;
      if (o_clip !== ref_clip(int'(smp), int'(g))) begin
        n_bad++;
        $display("FAIL rnd_clip[%0d]: got %b want %b", k, o_clip, ref_clip(int'(smp), int'(g)));
      end
    end
  endtask

  task automatic test_back_to_back();
    logic signed [15:0] smp;
    logic [1:0]         g;
    for (int k = 0; k < 4; k++) begin
      smp = 16'($urandom);
      g   = 2'($urandom);
      i_sample = smp; i_gain = g; i_strb = 1'b1;
      step();
      n_cmp++; if (o_valid !== 1'b1) begin n_bad++; $display("FAIL b2b_valid[%0d]: got %b want 1", k, o_valid); end
      n_cmp++;
      if (o_u8 !== ref_u8(ref_hold(int'(smp), int'(g)))) begin
        n_bad++;
        $display("FAIL b2b_u8[%0d]: got %h want %h", k, o_u8, ref_u8(ref_hold(int'(smp), int'(g))));
      end
    end
    i_strb = 1'b0;
    step();
    n_cmp++; if (o_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_valid_end: got %b want 0", o_valid); end
  endtask

  // Over N cycles a phase accumulator of step u emits floor((r0 + N*u)/65536) carries.
  task automatic test_ds1_density();
    int ones;
    int u;
    int lo;
    int bad;
    logic prev;
    i_mode = 2'b00;
    capture(16'sh4000, 2'd0);
    run(4096, ones);
    n_cmp++; if (ones != 3072) begin n_bad++; $display("FAIL ds1_c000: got %0d ones want 3072", ones); end
    for (int k = 0; k < 4; k++) begin
      u = int'($urandom_range(65535, 0));
      capture(16'(u - 32768), 2'd0);
      run(256, ones);
      lo = (256 * u) / 65536;
      n_cmp++;
      if (ones < lo || ones > lo + 1) begin
        n_bad++;
        $display("FAIL ds1_rand[%0d]: got %0d ones want %0d..%0d (u %h)", k, ones, lo, lo + 1, u);
      end
    end
    capture(16'sh0000, 2'd0);
    run(4, ones);
    prev = o_bit;
    bad  = 0;
    for (int j = 0; j < 32; j++) begin
      step();
      if (o_bit === prev) bad++;
      prev = o_bit;
    end
    n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL ds1_zero_alt: got %0d non-toggles want 0", bad); end
  endtask

  // Switches 00 -> 10 mid-run with a coincident strobe; duty follows the sample
  // held at the end of the previous 256-clock period.
  task automatic test_mode_switch_pwm();
    int ones;
    int duty_m;
    int held;
    int shape_bad;
    capture(16'sh7F00, 2'd0);
    run(16, ones);
    i_mode = 2'b10; i_sample = 16'shC000; i_gain = 2'd0; i_strb = 1'b1;
    step();
    i_strb = 1'b0;
    n_cmp++; if (o_bit !== 1'b0)   begin n_bad++; $display("FAIL modesw_bit: got %b want 0", o_bit); end
    n_cmp++; if (o_valid !== 1'b1) begin n_bad++; $display("FAIL modesw_valid: got %b want 1", o_valid); end
    duty_m = 0;
    held   = 8'h40;
    for (int p = 0; p < 5; p++) begin
      ones      = 0;
      shape_bad = 0;
      for (int j = 0; j < 256; j++) begin
        if (p == 2 && j == 100) begin
          i_sample = 16'sh4000; i_gain = 2'd0; i_strb = 1'b1;
        end
        step();
        i_strb = 1'b0;
        if (p == 2 && j == 100) held = 8'hC0;
        ones += int'(o_bit);
        if (o_bit !== (j < duty_m)) shape_bad++;
      end
      n_cmp++;
      if (ones != duty_m) begin
        n_bad++; $display("FAIL pwm_ones[%0d]: got %0d want %0d", p, ones, duty_m);
      end
      n_cmp++;
      if (shape_bad != 0) begin
        n_bad++; $display("FAIL pwm_shape[%0d]: got %0d misplaced bits want 0", p, shape_bad);
      end
      duty_m = held;
    end
  endtask

  task automatic test_raw_ds2();
    int levels[5] = '{-32768, -16384, 0, 16384, 32767};
    int ones;
    int expd;
    int dev;
    for (int k = 0; k < 5; k++) begin
      i_mode = 2'b11;
      capture(16'(levels[k]), 2'd0);
      step();
      step();
      n_cmp++;
      if (o_bit !== (levels[k] < 0)) begin
        n_bad++; $display("FAIL raw_bit[%0d]: got %b want %b", k, o_bit, levels[k] < 0);
      end
      i_mode = 2'b01;
      step();
      run(4096, ones);
      expd = ((levels[k] + 32768) * 4096) / 65536;
      dev  = ones - expd;
      n_cmp++;
      if (dev > 64 || dev < -64) begin
        n_bad++; $display("FAIL ds2_density[%0d]: got %0d ones want %0d +/-64", k, ones, expd);
      end
    end
  endtask

  task automatic test_reset_midstream();
    rst = 1'b1; i_strb = 1'b1; i_sample = 16'sh1234; i_gain = 2'd0;
    step();
    n_cmp++; if (o_valid !== 1'b0) begin n_bad++; $display("FAIL rstmid_valid: got %b want 0", o_valid); end
    n_cmp++; if (o_u8 !== 8'h80)   begin n_bad++; $display("FAIL rstmid_u8: got %h want 80", o_u8); end
    n_cmp++; if (o_bit !== 1'b0)   begin n_bad++; $display("FAIL rstmid_bit: got %b want 0", o_bit); end
    rst = 1'b0; i_strb = 1'b0;
    step();
    n_cmp++; if (o_valid !== 1'b0) begin n_bad++; $display("FAIL rstmid_after: got %b want 0", o_valid); end
    n_cmp++; if (o_u8 !== 8'h80)   begin n_bad++; $display("FAIL rstmid_hold: got %h want 80", o_u8); end
  endtask

  initial begin
    test_reset();
    test_capture();
    test_gain_sat();
    test_random_capture();
    test_back_to_back();
    test_ds1_density();
    test_mode_switch_pwm();
    test_raw_ds2();
    test_reset_midstream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
